// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour BCD clock with NUM_ALARMS independently enabled
// alarms and a ring state machine with timed auto-silence.
// Optional snooze (input port `snooze`, state SNOOZED) is compiled in when the
// macro ALARM_CLOCK_SNOOZE_EN is defined; the default build has no snooze.
module alarm_clock_multi #(
  parameter int CLK_HZ      = 50000000,
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 300,
  parameter int SNOOZE_SECS = 300,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [1:0]            field_sel,
  input  logic [AW-1:0]         alarm_sel,
  input  logic                  increment,
  input  logic                  alarm_toggle,
  input  logic                  dismiss,
`ifdef ALARM_CLOCK_SNOOZE_EN
  input  logic                  snooze,
`endif
  output logic                  tick_1hz,
  output logic [23:0]           time_bcd,
  output logic [23:0]           display_bcd,
  output logic [NUM_ALARMS-1:0] alarm_en_mask,
  output logic                  ringing,
  output logic [AW-1:0]         ring_id,
  output logic [7:0]            vol
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  // One counter serves both the ring and snooze timeouts, sized for the longer one.
  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW = $clog2(MAX_SECS + 1);

`ifdef ALARM_CLOCK_SNOOZE_EN
  localparam int NIN = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RINGING = 2'd1, ST_SNOOZED = 2'd2} state_t;
`else
  localparam int NIN = 3;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RINGING = 1'b1} state_t;
`endif

  // ---------------------------------------------------------------- helpers
  // +1 on a 00..59 BCD field, wrapping to 00 without carry out.
  function automatic logic [7:0] inc_sm(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // +1 on a 00..23 BCD hour field, wrapping 23 -> 00.
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)           r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Edit one field of an HHMMSS value, no carry into neighbouring fields.
  function automatic logic [23:0] inc_field(input logic [23:0] t, input logic [1:0] f);
    logic [23:0] r;
    case (f)
      2'b01:   r = {t[23:8], inc_sm(t[7:0])};
      2'b10:   r = {t[23:16], inc_sm(t[15:8]), t[7:0]};
      2'b11:   r = {inc_hr(t[23:16]), t[15:0]};
      default: r = t;
    endcase
    return r;
  endfunction

  // One-second advance with full carry chain, 23:59:59 -> 00:00:00.
  function automatic logic [23:0] tick_time(input logic [23:0] t);
    logic [23:0] r;
    r = {t[23:8], inc_sm(t[7:0])};
    if (t[7:0] == 8'h59) begin
      r[15:8] = inc_sm(t[15:8]);
      if (t[15:8] == 8'h59) r[23:16] = inc_hr(t[23:16]);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- signals
  logic [PW-1:0]  pre_q, pre_d;
  logic [23:0]    time_q, time_d;
  logic           chg_q, chg_d;
  logic [NIN-1:0] in_s_q, in_p_q, raw_in, act;
  logic           inc_act, tgl_act, dis_act;
  logic           set_clock, set_alarm, set_mode, run_mode, sel_ok, tick;
  logic [23:0]           alarm_val [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_mask, en_next, match_vec;
  logic                  match_hit;
  logic [AW-1:0]         match_id;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  ring_id_q, ring_id_d;
  logic           ringing_q, ringing_d;
  logic [7:0]     vol_q, vol_d;

`ifdef ALARM_CLOCK_SNOOZE_EN
  logic snz_act;
  assign raw_in  = {snooze, dismiss, alarm_toggle, increment};
  assign snz_act = act[3];
`else
  assign raw_in  = {dismiss, alarm_toggle, increment};
`endif

  // Rising-edge actions come from the registered input versus its previous sample.
  assign act     = in_s_q & ~in_p_q;
  assign inc_act = act[0];
  assign tgl_act = act[1];
  assign dis_act = act[2];

  assign set_clock = (mode == 2'b01);
  assign set_alarm = (mode == 2'b10);
  assign set_mode  = set_clock | set_alarm;
  assign run_mode  = ~set_mode;
  assign sel_ok    = ({1'b0, alarm_sel} < (AW + 1)'(NUM_ALARMS));
  assign tick      = ~set_clock && (pre_q == PW'(CLK_HZ - 1));

  // Prescaler and time-of-day next state; the prescaler is parked while setting the clock.
  always_comb begin
    pre_d  = '0;
    time_d = time_q;
    if (!set_clock) pre_d = (pre_q == PW'(CLK_HZ - 1)) ? '0 : pre_q + PW'(1);
    if (tick)                      time_d = tick_time(time_q);
    else if (set_clock && inc_act) time_d = inc_field(time_q, field_sel);
    chg_d = (time_d != time_q);
  end

  // Clock-side registers: prescaler, time, change flag and edge-detect samples.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      time_q <= '0;
      chg_q  <= 1'b0;
      in_s_q <= '0;
      in_p_q <= '0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
      chg_q  <= chg_d;
      in_s_q <= raw_in;
      in_p_q <= in_s_q;
    end
  end

  // One alarm slot per index: value, enable bit and match against current time.
  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
    logic [23:0] alm_q, alm_d;
    logic        en_q, en_d, sel_this;

    assign sel_this = sel_ok && (alarm_sel == AW'(gi));

    // Field edits only in set-alarm mode; toggles act in any mode.
    always_comb begin
      alm_d = alm_q;
      en_d  = en_q;
      if (set_alarm && inc_act && sel_this) alm_d = inc_field(alm_q, field_sel);
      if (tgl_act && sel_this)              en_d  = ~en_q;
    end

    // Alarm slot storage.
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        alm_q <= '0;
        en_q  <= 1'b0;
      end else begin
        alm_q <= alm_d;
        en_q  <= en_d;
      end
    end

    assign alarm_val[gi] = alm_q;
    assign en_mask[gi]   = en_q;
    assign en_next[gi]   = en_d;
    assign match_vec[gi] = en_q && (alm_q == time_q);
  end

  // Lowest-index enabled alarm equal to the current time.
  always_comb begin
    match_hit = 1'b0;
    match_id  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_hit = 1'b1;
        match_id  = AW'(i);
      end
    end
  end

  // Ring FSM next state; a fire needs a fresh time change seen in run mode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ring_id_d = ring_id_q;
    case (state_q)
      ST_IDLE: begin
        if (chg_q && run_mode && match_hit && !dis_act) begin
          state_d   = ST_RINGING;
          ring_id_d = match_id;
          cnt_d     = '0;
        end
      end
      ST_RINGING: begin
        if (dis_act || set_mode || !en_next[ring_id_q]) begin
          state_d = ST_IDLE;
`ifdef ALARM_CLOCK_SNOOZE_EN
        end else if (snz_act) begin
          state_d = ST_SNOOZED;
          cnt_d   = '0;
`endif
        end else if (tick) begin
          if (cnt_q == CW'(RING_SECS - 1)) state_d = ST_IDLE;
          else                             cnt_d   = cnt_q + CW'(1);
        end
      end
`ifdef ALARM_CLOCK_SNOOZE_EN
      ST_SNOOZED: begin
        if (dis_act || set_mode || !en_next[ring_id_q]) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt_q == CW'(SNOOZE_SECS - 1)) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    ringing_d = (state_d == ST_RINGING);
    vol_d     = ringing_d ? 8'h80 : 8'h00;
  end

  // Ring FSM registers, including the registered audio outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ring_id_q <= '0;
      ringing_q <= 1'b0;
      vol_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ring_id_q <= ring_id_d;
      ringing_q <= ringing_d;
      vol_q     <= vol_d;
    end
  end

  // Display mux: the selected alarm while editing alarms, otherwise the time.
  always_comb begin
    display_bcd = time_q;
    if (set_alarm) display_bcd = sel_ok ? alarm_val[alarm_sel] : 24'h000000;
  end

  assign tick_1hz      = tick;
  assign time_bcd      = time_q;
  assign alarm_en_mask = en_mask;
  assign ringing       = ringing_q;
  assign ring_id       = ring_id_q;
  assign vol           = vol_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Testbench for alarm_clock_multi: directed scenarios followed by random
// stimulus, all checked every cycle against a seconds-of-day reference model.
module tb_alarm_clock_multi;
  localparam int CLK_HZ = 4;
  localparam int NA     = 4;
  localparam int RING   = 3;
  localparam int SNZ    = 2;
  localparam int AW     = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode, field_sel;
  logic [AW-1:0] alarm_sel;
  logic          increment, alarm_toggle, dismiss, snooze;
  logic          tick_1hz, ringing;
  logic [23:0]   time_bcd, display_bcd;
  logic [NA-1:0] alarm_en_mask;
  logic [AW-1:0] ring_id;
  logic [7:0]    vol;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_clock_multi #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .CLK(clk), .reset(reset), .mode(mode), .field_sel(field_sel), .alarm_sel(alarm_sel),
    .increment(increment), .alarm_toggle(alarm_toggle), .dismiss(dismiss),
`ifdef ALARM_CLOCK_SNOOZE_EN
    .snooze(snooze),
`endif
    .tick_1hz(tick_1hz), .time_bcd(time_bcd), .display_bcd(display_bcd),
    .alarm_en_mask(alarm_en_mask), .ringing(ringing), .ring_id(ring_id), .vol(vol)
  );

  // Reference model: time and alarms as seconds of the day, state 0 idle / 1 ringing / 2 snoozed.
  int m_sec, m_pre, m_state, m_id, m_cnt;
  int m_alm [NA];
  bit m_en [NA];
  bit m_chg;
  bit s1 [4];
  bit s2 [4];

  function automatic int bump(input int t, input logic [1:0] f);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    case (f)
      2'b01:   s  = (s + 1) % 60;
      2'b10:   mi = (mi + 1) % 60;
      2'b11:   h  = (h + 1) % 24;
      default: ;
    endcase
    return h * 3600 + mi * 60 + s;
  endfunction

  function automatic logic [23:0] bcd(input int t);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_pre = 0; m_state = 0; m_id = 0; m_cnt = 0; m_chg = 1'b0;
    for (int i = 0; i < NA; i++) begin m_alm[i] = 0; m_en[i] = 1'b0; end
    for (int i = 0; i < 4; i++) begin s1[i] = 1'b0; s2[i] = 1'b0; end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_update();
    bit act [4];
    bit in_now [4];
    bit run, tk;
    int nsec, hit;
    int nalm [NA];
    bit nen [NA];
    in_now = '{increment, alarm_toggle, dismiss, snooze};
    for (int i = 0; i < 4; i++) act[i] = s1[i] && !s2[i];
    run  = (mode == 2'b00) || (mode == 2'b11);
    tk   = (mode != 2'b01) && (m_pre == CLK_HZ - 1);
    nsec = m_sec;
    if (tk) nsec = (m_sec + 1) % 86400;
    else if (mode == 2'b01 && act[0]) nsec = bump(m_sec, field_sel);
    nalm = m_alm;
    nen  = m_en;
    if (mode == 2'b10 && act[0] && alarm_sel < NA) nalm[alarm_sel] = bump(m_alm[alarm_sel], field_sel);
    if (act[1] && alarm_sel < NA) nen[alarm_sel] = !m_en[alarm_sel];
    hit = -1;
    if (m_chg && run)
      for (int i = NA - 1; i >= 0; i--) if (m_en[i] && m_alm[i] == m_sec) hit = i;
    case (m_state)
      0: if (hit >= 0 && !act[2]) begin m_state = 1; m_id = hit; m_cnt = 0; end
      1: begin
        if (act[2] || !run || !nen[m_id]) m_state = 0;
        else if (act[3]) begin m_state = 2; m_cnt = 0; end
        else if (tk) begin m_cnt++; if (m_cnt == RING) m_state = 0; end
      end
      default: begin
        if (act[2] || !run || !nen[m_id]) m_state = 0;
        else if (tk) begin m_cnt++; if (m_cnt == SNZ) begin m_state = 1; m_cnt = 0; end end
      end
    endcase
    m_chg = (nsec != m_sec);
    m_sec = nsec;
    m_alm = nalm;
    m_en  = nen;
    m_pre = (mode == 2'b01) ? 0 : (m_pre + 1) % CLK_HZ;
    s2 = s1;
    s1 = in_now;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NA-1:0] em;
    logic [23:0]   ed;
    for (int i = 0; i < NA; i++) em[i] = m_en[i];
    ed = bcd(m_sec);
    if (mode == 2'b10) ed = (alarm_sel < NA) ? bcd(m_alm[alarm_sel]) : 24'h0;
    chk("tick_1hz", {31'b0, tick_1hz}, {31'b0, (mode != 2'b01) && (m_pre == CLK_HZ - 1)});
    chk("time_bcd", {8'b0, time_bcd}, {8'b0, bcd(m_sec)});
    chk("display_bcd", {8'b0, display_bcd}, {8'b0, ed});
    chk("alarm_en_mask", {28'b0, alarm_en_mask}, {28'b0, em});
    chk("ringing", {31'b0, ringing}, {31'b0, m_state == 1});
    chk("ring_id", {30'b0, ring_id}, m_id);
    chk("vol", {24'b0, vol}, (m_state == 1) ? 32'h80 : 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic pulse_inc(input logic [1:0] f);
    field_sel = f; increment = 1'b1; step();
    increment = 1'b0; step();
  endtask

  task automatic toggle(input logic [AW-1:0] a);
    alarm_sel = a; alarm_toggle = 1'b1; step();
    alarm_toggle = 1'b0; step();
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    mode = 2'b01;
    while (m_sec / 3600 != h)       pulse_inc(2'b11);
    while ((m_sec / 60) % 60 != mi) pulse_inc(2'b10);
    while (m_sec % 60 != s)         pulse_inc(2'b01);
  endtask

  task automatic wait_ringing(input string tag);
    int n;
    n = 0;
    while (ringing !== 1'b1 && n < 60) begin step(); n++; end
    chk(tag, {31'b0, ringing}, 32'd1);
  endtask

  initial begin
    int n, r;
    reset = 1'b1; mode = 2'b00; field_sel = 2'b00; alarm_sel = '0;
    increment = 1'b0; alarm_toggle = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Prescaler: tick on the fourth cycle, time advances on the next.
    step(); step(); step();
    chk("tick_cycle4", {31'b0, tick_1hz}, 32'd1);
    step();
    chk("time_after_tick", {8'b0, time_bcd}, 32'h000001);

    // Full-day rollover.
    set_time(23, 59, 58);
    mode = 2'b00;
    repeat (4) step();
    chk("roll_235959", {8'b0, time_bcd}, 32'h235959);
    repeat (4) step();
    chk("roll_000000", {8'b0, time_bcd}, 32'h000000);

    // Field edits wrap without carry.
    set_time(0, 59, 59);
    pulse_inc(2'b01);
    chk("sec_wrap_no_carry", {8'b0, time_bcd}, 32'h005900);
    set_time(23, 59, 0);
    pulse_inc(2'b11);
    chk("hr_wrap", {8'b0, time_bcd}, 32'h005900);

    // Alarms 1 and 2 at 00:00:05, both enabled.
    mode = 2'b10;
    alarm_sel = 2'd1;
    while (m_alm[1] != 5) pulse_inc(2'b01);
    alarm_sel = 2'd2;
    while (m_alm[2] != 5) pulse_inc(2'b01);
    chk("display_alarm2", {8'b0, display_bcd}, 32'h000005);
    toggle(2'd1);
    toggle(2'd2);
    chk("mask_0110", {28'b0, alarm_en_mask}, 32'h6);

    // Fire one cycle after the time match, lowest index wins, then auto-silence.
    set_time(0, 0, 0);
    mode = 2'b00; alarm_sel = '0;
    n = 0;
    while (time_bcd !== 24'h000005 && n < 60) begin step(); n++; end
    chk("reach_000005", {8'b0, time_bcd}, 32'h000005);
    chk("quiet_at_match", {31'b0, ringing}, 32'd0);
    step();
    chk("ring_fire", {31'b0, ringing}, 32'd1);
    chk("ring_id_1", {30'b0, ring_id}, 32'd1);
    chk("vol_80", {24'b0, vol}, 32'h80);
    n = 0;
    while (ringing === 1'b1 && n < 60) begin step(); n++; end
    chk("auto_silence_time", {8'b0, time_bcd}, 32'h000008);
    chk("mask_kept", {28'b0, alarm_en_mask}, 32'h6);

    // Dismiss silences two cycles after the rising edge.
    set_time(0, 0, 0);
    mode = 2'b00;
    wait_ringing("ring_again");
    dismiss = 1'b1; step();
    chk("dismiss_lag", {31'b0, ringing}, 32'd1);
    step();
    chk("dismissed", {31'b0, ringing}, 32'd0);
    chk("dismissed_vol", {24'b0, vol}, 32'h0);
    dismiss = 1'b0; step();

    // Entering a set mode forces idle.
    set_time(0, 0, 0);
    mode = 2'b00;
    wait_ringing("ring_third");
    mode = 2'b01; step();
    chk("mode_silence", {31'b0, ringing}, 32'd0);
    mode = 2'b00;

`ifdef ALARM_CLOCK_SNOOZE_EN
    // Snooze for two ticks, then ring again with the same id; snooze+dismiss gives idle.
    set_time(0, 0, 0);
    mode = 2'b00;
    wait_ringing("ring_snooze");
    snooze = 1'b1; step(); step();
    chk("snoozed_quiet", {31'b0, ringing}, 32'd0);
    snooze = 1'b0;
    wait_ringing("snooze_resume");
    chk("snooze_same_id", {30'b0, ring_id}, 32'd1);
    snooze = 1'b1; dismiss = 1'b1; step(); step();
    snooze = 1'b0; dismiss = 1'b0;
    repeat (12) step();
    chk("snooze_dismiss_idle", {31'b0, ringing}, 32'd0);
`endif

    // Random stimulus around an armed alarm; the model checks every cycle.
    set_time(0, 0, 0);
    mode = 2'b10; alarm_sel = 2'd0;
    while (m_alm[0] != 3) pulse_inc(2'b01);
    toggle(2'd0);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      mode         = (r < 6) ? 2'b00 : (r < 7) ? 2'b11 : (r < 8) ? 2'b01 : 2'b10;
      field_sel    = 2'($urandom_range(0, 3));
      alarm_sel    = AW'($urandom_range(0, NA - 1));
      increment    = ($urandom_range(0, 3) == 0);
      alarm_toggle = ($urandom_range(0, 7) == 0);
      dismiss      = ($urandom_range(0, 7) == 0);
`ifdef ALARM_CLOCK_SNOOZE_EN
      snooze       = ($urandom_range(0, 5) == 0);
`endif
      if ((k % 40) == 0) begin
        mode = 2'b01;
        set_time(0, 0, 0);
        mode = 2'b00;
      end
      repeat ($urandom_range(1, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
